int2flt_noround_seq: RTL and testbench

//  Sequential 16-bit two's-complement integer -> IEEE half-precision float converter, no rounding (mantissa truncated).

---
 rtl/int2flt_noround_seq_if.sv | 15 +
 rtl/int2flt_noround_seq.sv | 96 +++++++++
 tb/tb_int2flt_noround_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/int2flt_noround_seq_if.sv
// Start/done handshake plus byte-wide data_mem port shared by the int<->float stages.
interface int2flt_noround_seq_if #(parameter int ADDR_W = 8);
  logic              start;
  logic              done;
  logic              busy;
  logic [ADDR_W-1:0] dm_addr;
  logic [7:0]        dm_rd_data;
  logic [7:0]        dm_wr_data;
  logic              dm_wr_en;

  modport master (output start, dm_rd_data,
                  input  done, busy, dm_addr, dm_wr_data, dm_wr_en);
  modport slave  (input  start, dm_rd_data,
                  output done, busy, dm_addr, dm_wr_data, dm_wr_en);
endinterface

// File: rtl/int2flt_noround_seq.sv
// 16-bit signed int -> half float, truncating. Reads SRC from data_mem, normalises
// one bit per cycle, writes the packed float to DST.
module int2flt_noround_seq #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] SRC_ADDR = 8'd0,
  parameter logic [ADDR_W-1:0] DST_ADDR = 8'd2
) (
  input  logic                  clk,
  input  logic                  reset,
  int2flt_noround_seq_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, RD_LO, RD_HI, ABS, NORM, PACK, WR_LO, WR_HI, DONE
  } state_t;

  state_t            state, state_nx;
  logic              start_q;
  logic [15:0]       int_r;
  logic [15:0]       mag;
  logic [3:0]        shift_cnt;
  logic              sign;
  logic [15:0]       result;

  logic              done_c, busy_c, wr_en_c;
  logic [ADDR_W-1:0] addr_c;
  logic [7:0]        wr_data_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    done_c    = 1'b0;
    busy_c    = (state != IDLE);
    wr_en_c   = 1'b0;
    addr_c    = '0;
    wr_data_c = 8'h00;
    case (state)
      IDLE:  if (start_q && !bus.start) state_nx = RD_LO;
      RD_LO: begin addr_c = SRC_ADDR;        state_nx = RD_HI; end
      RD_HI: begin addr_c = SRC_ADDR + 1'b1; state_nx = ABS;   end
      // |int| is zero exactly when int is zero, so decide before mag is loaded
      ABS:   state_nx = (int_r == 16'h0000) ? PACK : NORM;
      // leave on the cycle the shift lands the leading one in bit 15
      NORM:  if (mag[15] || mag[14]) state_nx = PACK;
      PACK:  state_nx = WR_LO;
      WR_LO: begin
        addr_c = DST_ADDR; wr_data_c = result[7:0];  wr_en_c = 1'b1; state_nx = WR_HI;
      end
      WR_HI: begin
        addr_c = DST_ADDR + 1'b1; wr_data_c = result[15:8]; wr_en_c = 1'b1; state_nx = DONE;
      end
      DONE:  begin done_c = 1'b1; state_nx = IDLE; end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q   <= 1'b0;
      int_r     <= '0;
      sign      <= 1'b0;
      mag       <= '0;
      shift_cnt <= '0;
      result    <= '0;
    end else begin
      start_q <= bus.start;
      case (state)
        RD_LO: int_r[7:0]  <= bus.dm_rd_data;
        RD_HI: int_r[15:8] <= bus.dm_rd_data;
        ABS: begin
          sign      <= int_r[15];
          mag       <= int_r[15] ? (~int_r + 16'd1) : int_r;
          shift_cnt <= '0;
        end
        NORM: if (!mag[15]) begin
          mag       <= {mag[14:0], 1'b0};
          shift_cnt <= shift_cnt + 4'd1;
        end
        PACK: result <= (mag == 16'h0000) ? 16'h0000
                        : {sign, 5'd30 - {1'b0, shift_cnt}, mag[14:5]};
        default: ;
      endcase
    end
  end

  assign bus.done       = done_c;
  assign bus.busy       = busy_c;
  assign bus.dm_addr    = addr_c;
  assign bus.dm_wr_data = wr_data_c;
  assign bus.dm_wr_en   = wr_en_c;

endmodule

// File: tb/tb_int2flt_noround_seq.sv
// Scoreboard bench for int2flt_noround_seq with a behavioural data_mem.
module tb_int2flt_noround_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int2flt_noround_seq_if #(.ADDR_W(8)) bus ();
  int2flt_noround_seq dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0]  mem [256];
  logic        ld_req = 1'b0;
  logic [15:0] ld_src = '0, ld_dst = '0;

  assign bus.dm_rd_data = mem[bus.dm_addr];

  always @(posedge clk) begin
    if (bus.dm_wr_en) mem[bus.dm_addr] <= bus.dm_wr_data;
    else if (ld_req) begin
      mem[0] <= ld_src[7:0]; mem[1] <= ld_src[15:8];
      mem[2] <= ld_dst[7:0]; mem[3] <= ld_dst[15:8];
    end
  end

  typedef struct { logic [15:0] res; int lat; logic [15:0] src; } exp_t;
  exp_t sb[$];

  int n_tests = 0, n_fail = 0;
  int done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] v, output int lat);
    logic [15:0] m, mn;
    int p, lz;
    if (v == 16'h0000) begin lat = 6; return 16'h0000; end
    m = v[15] ? (16'h0000 - v) : v;
    p = 15;
    while (!m[p]) p--;
    lz = 15 - p;
    mn = m << lz;
    lat = 6 + ((lz == 0) ? 1 : lz);
    return {v[15], 5'(15 + p), mn[14:5]};
  endfunction

  // monitor: latency from busy rise (RD_LO) to done, result pop on done
  int lat = 0;
  logic busy_d = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.busy && !busy_d) lat = 0;
    else if (bus.busy)       lat++;
    busy_d = bus.busy;
    if (bus.dm_wr_en && bus.dm_addr < 8'd2) chk("src_write", {24'h0, bus.dm_addr}, 32'hFF);
    if (bus.done) begin
      done_cnt++;
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk($sformatf("result_%04h", e.src), {mem[3], mem[2]}, e.res);
        chk($sformatf("latency_%04h", e.src), lat, e.lat);
        chk("busy_at_done", bus.busy, 1);
        chk("src_intact", {mem[1], mem[0]}, e.src);
      end
    end
  end

  task automatic load(input logic [15:0] src, input logic [15:0] dst);
    @(negedge clk);
    ld_src = src; ld_dst = dst; ld_req = 1'b1;
    @(posedge clk); #1 ld_req = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] v);
    exp_t e;
    e.src = v;
    e.res = model(v, e.lat);
    sb.push_back(e);
  endtask

  task automatic wait_done(input int n0);
    int t = 0;
    while (done_cnt == n0 && t < 100) begin @(negedge clk); #2; t++; end
    if (done_cnt == n0) chk("timeout", 0, 1);
  endtask

  task automatic run(input logic [15:0] v);
    int n0;
    load(v, 16'hAAAA);
    push_exp(v);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    n0 = done_cnt;
    wait_done(n0);
    @(negedge clk);
  endtask

  initial begin
    int n0;
    bus.start = 1'b0;
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_wr_en", bus.dm_wr_en, 0);
    chk("rst_addr", bus.dm_addr, 0);
    chk("rst_wr_data", bus.dm_wr_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run(16'h03E8);
    run(16'h0001);
    run(16'hFFFF);
    run(16'h0000);
    run(16'h8000);
    run(16'h7FFF);
    run(16'h0400);
    run(16'hFC18);
    for (int i = 0; i < 6; i++) run(16'($urandom_range(0, 65535)));

    // reset during NORM of 0x0001, with start held high through reset
    load(16'h0001, 16'hAAAA);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset = 1'b1; bus.start = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_wr_en", bus.dm_wr_en, 0);
    chk("abort_addr", bus.dm_addr, 0);
    chk("abort_done", bus.done, 0);
    n0 = done_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("held_start_idle", bus.busy, 0);
    end
    chk("abort_no_done", done_cnt - n0, 0);
    chk("abort_dst_untouched", {mem[3], mem[2]}, 16'hAAAA);
    push_exp(16'h0001);
    bus.start = 1'b0;
    wait_done(n0);
    @(negedge clk);

    // start activity while busy is ignored
    load(16'h03E8, 16'h5555);
    push_exp(16'h03E8);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    n0 = done_cnt;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    wait_done(n0);
    repeat (30) @(negedge clk);
    chk("one_done_per_req", done_cnt - n0, 1);
    chk("busy_idle_after", bus.busy, 0);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
